// File: rtl/m_scroll_disp.sv
// Scrolling 4-digit seven-segment message display fed from an external 16-entry message ROM.
// Optional macro M_SCROLL_DISP_DIR_EN adds a 'dir' input for reverse scrolling.
module m_scroll_disp #(
   parameter int REFRESH_DIV = 50000,
   parameter int SCROLL_DIV  = 25000000
) (
   input  logic       clk,
`ifdef M_SCROLL_DISP_DIR_EN
   input  logic       dir,
`endif
   input  logic       rst,
   input  logic       mode_in,
   input  logic       pause,
   input  logic [7:0] rom_dat,
   output logic [3:0] rom_adr,
   output logic       rom_mode,
   output logic [7:0] seg,
   output logic [3:0] an,
   output logic       busy
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int SCR_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_DIV - 1);

   typedef enum logic {FILL, SHOW} state_t;

   state_t     r_state, w_stateNext;
   logic [1:0] r_k, w_kNext;
   logic [3:0] r_offset, w_offsetNext, w_stepOffset;
   logic       r_romMode, w_romModeNext;
   logic       r_pending, w_pendingNext;
   logic       w_dispLoad;
   logic       w_scrollTick;

   logic [7:0] r_fillBuf [4];
   logic [7:0] r_dispBuf [4];

   logic [REF_W-1:0] r_refCnt;
   logic [SCR_W-1:0] r_scrCnt;
   logic [1:0]       r_digit;
   logic [1:0]       w_digitNext;
   logic [7:0]       r_seg;
   logic [3:0]       r_an;

   assign w_scrollTick = !pause && (r_scrCnt == SCR_LAST);

`ifdef M_SCROLL_DISP_DIR_EN
   assign w_stepOffset = dir ? (r_offset - 4'd1) : (r_offset + 4'd1);
`else
   assign w_stepOffset = r_offset + 4'd1;
`endif

   // Next-state logic: a mode change beats a scroll tick, and ticks arriving mid-fill are parked in r_pending.
   always_comb begin
      w_stateNext   = r_state;
      w_kNext       = r_k;
      w_offsetNext  = r_offset;
      w_romModeNext = r_romMode;
      w_pendingNext = r_pending;
      w_dispLoad    = 1'b0;
      case (r_state)
         FILL: begin
            w_pendingNext = r_pending | w_scrollTick;
            w_kNext       = r_k + 2'd1;
            if (r_k == 2'd3) begin
               w_stateNext = SHOW;
               w_dispLoad  = 1'b1;
            end
         end
         SHOW: begin
            if (mode_in != r_romMode) begin
               w_romModeNext = mode_in;
               w_offsetNext  = 4'd0;
               w_pendingNext = 1'b0;
               w_stateNext   = FILL;
               w_kNext       = 2'd0;
            end else if (w_scrollTick || r_pending) begin
               w_offsetNext  = w_stepOffset;
               w_pendingNext = 1'b0;
               w_stateNext   = FILL;
               w_kNext       = 2'd0;
            end
         end
         default: begin
            w_stateNext = FILL;
            w_kNext     = 2'd0;
         end
      endcase
   end

   // State register plus the fill and display buffers; the last character goes straight from rom_dat into disp_buf.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FILL;
         r_k       <= 2'd0;
         r_offset  <= 4'd0;
         r_romMode <= mode_in;
         r_pending <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_fillBuf[i] <= 8'hFF;
            r_dispBuf[i] <= 8'hFF;
         end
      end else begin
         r_state   <= w_stateNext;
         r_k       <= w_kNext;
         r_offset  <= w_offsetNext;
         r_romMode <= w_romModeNext;
         r_pending <= w_pendingNext;
         if (r_state == FILL) begin
            r_fillBuf[r_k] <= rom_dat;
         end
         if (w_dispLoad) begin
            r_dispBuf[0] <= r_fillBuf[0];
            r_dispBuf[1] <= r_fillBuf[1];
            r_dispBuf[2] <= r_fillBuf[2];
            r_dispBuf[3] <= rom_dat;
         end
      end
   end

   assign w_digitNext = r_digit + 2'd1;

   // Digit multiplexing: seg/an only move on refresh ticks, independent of pause.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_refCnt <= '0;
         r_digit  <= 2'd3;
         r_seg    <= 8'hFF;
         r_an     <= 4'b1111;
      end else if (r_refCnt == REF_LAST) begin
         r_refCnt <= '0;
         r_digit  <= w_digitNext;
         r_an     <= ~(4'b0001 << w_digitNext);
         r_seg    <= r_dispBuf[w_digitNext];
      end else begin
         r_refCnt <= r_refCnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_scrCnt <= '0;
      end else if (!pause) begin
         r_scrCnt <= (r_scrCnt == SCR_LAST) ? '0 : r_scrCnt + 1'b1;
      end
   end

   assign rom_adr  = (r_state == FILL) ? (r_offset + {2'b00, r_k}) : r_offset;
   assign rom_mode = r_romMode;
   assign busy     = (r_state == FILL);
   assign seg      = r_seg;
   assign an       = r_an;

endmodule

// File: tb/tb_m_scroll_disp.sv
// Self-checking bench for m_scroll_disp: directed boot/pending/reset steps plus randomized pause, mode and reset
// traffic, all compared every cycle against a window-level reference model of the scrolling display.
module tb_m_scroll_disp;

   localparam int REFRESH_DIV = 4;
   localparam int SCROLL_DIV  = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode_in = 1'b0;
   logic       pause = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] rom_dat;
   logic [3:0] rom_adr;
   logic       rom_mode;
   logic [7:0] seg;
   logic [3:0] an;
   logic       busy;

   int nAsserts = 0;
   int nFails   = 0;

   // Reference model state: what the user would see, expressed as offset/mode/window rather than per-cycle captures.
   int         mOffset;
   logic       mMode;
   int         mFillLeft;
   bit         mPending;
   int         mRefCnt;
   int         mScrCnt;
   int         mDigit;
   logic [7:0] mWindow [4];
   logic [7:0] mSeg;
   logic [3:0] mAn;

   m_scroll_disp #(
      .REFRESH_DIV(REFRESH_DIV),
      .SCROLL_DIV (SCROLL_DIV)
   ) dut (
      .clk     (clk),
`ifdef M_SCROLL_DISP_DIR_EN
      .dir     (dir),
`endif
      .rst     (rst),
      .mode_in (mode_in),
      .pause   (pause),
      .rom_dat (rom_dat),
      .rom_adr (rom_adr),
      .rom_mode(rom_mode),
      .seg     (seg),
      .an      (an),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Message ROM: mode 0 "HELLO   " twice, mode 1 "GOOdbyE " twice.
   function automatic logic [7:0] romLookup(input logic m, input logic [3:0] a);
      logic [7:0] v;
      v = 8'hFF;
      if (!m) begin
         case (a[2:0])
            3'd0: v = 8'h89;
            3'd1: v = 8'h86;
            3'd2: v = 8'hC7;
            3'd3: v = 8'hC7;
            3'd4: v = 8'hC0;
            default: v = 8'hFF;
         endcase
      end else begin
         case (a[2:0])
            3'd0: v = 8'hC2;
            3'd1: v = 8'hC0;
            3'd2: v = 8'hC0;
            3'd3: v = 8'hA1;
            3'd4: v = 8'h83;
            3'd5: v = 8'h91;
            3'd6: v = 8'h86;
            default: v = 8'hFF;
         endcase
      end
      return v;
   endfunction

   assign rom_dat = romLookup(rom_mode, rom_adr);

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance the model by one rising edge using the inputs present at that edge.
   task automatic modelEdge();
      bit tick;
      int step;
      if (rst) begin
         mOffset   = 0;
         mMode     = mode_in;
         mFillLeft = 4;
         mPending  = 0;
         mRefCnt   = 0;
         mScrCnt   = 0;
         mDigit    = 3;
         mSeg      = 8'hFF;
         mAn       = 4'b1111;
         for (int j = 0; j < 4; j++) mWindow[j] = 8'hFF;
      end else begin
         tick = !pause && (mScrCnt == SCROLL_DIV - 1);
         if (!pause) mScrCnt = (mScrCnt + 1) % SCROLL_DIV;
         if (mRefCnt == REFRESH_DIV - 1) begin
            mRefCnt = 0;
            mDigit  = (mDigit + 1) % 4;
            mAn     = ~(4'(1 << mDigit));
            mSeg    = mWindow[mDigit];
         end else begin
            mRefCnt++;
         end
         if (mFillLeft > 0) begin
            if (tick) mPending = 1;
            if (mFillLeft == 1) begin
               for (int j = 0; j < 4; j++) mWindow[j] = romLookup(mMode, 4'((mOffset + j) % 16));
            end
            mFillLeft--;
         end else if (mode_in != mMode) begin
            mMode     = mode_in;
            mOffset   = 0;
            mPending  = 0;
            mFillLeft = 4;
         end else if (tick || mPending) begin
            step = 1;
`ifdef M_SCROLL_DISP_DIR_EN
            if (dir) step = 15;
`endif
            mOffset   = (mOffset + step) % 16;
            mPending  = 0;
            mFillLeft = 4;
         end
      end
   endtask

   // One clock: inputs already set by the caller, then compare every output against the model 1 ns after the edge.
   task automatic applyStimulus();
      int expAdr;
      @(posedge clk);
      modelEdge();
      #1;
      expAdr = (mFillLeft > 0) ? (mOffset + 4 - mFillLeft) % 16 : mOffset;
      checkOutput("busy", 8'(busy), 8'(mFillLeft > 0));
      checkOutput("rom_adr", 8'(rom_adr), 8'(expAdr));
      checkOutput("rom_mode", 8'(rom_mode), 8'(mMode));
      checkOutput("seg", seg, mSeg);
      checkOutput("an", 8'(an), 8'(mAn));
   endtask

   initial begin
      logic [7:0] obsSeg [4];
      int         guard;

      $display("[TB] start");
      for (int j = 0; j < 4; j++) obsSeg[j] = 8'h00;

      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("resetSeg", seg, 8'hFF);
      checkOutput("resetAn", 8'(an), 8'h0F);
      rst = 1'b0;

      // Boot fill walks addresses 0..3 with busy high, then settles.
      for (int i = 0; i < 4; i++) begin
         checkOutput("bootAdr", 8'(rom_adr), 8'(i));
         checkOutput("bootBusy", 8'(busy), 8'h01);
         applyStimulus();
      end
      checkOutput("bootDone", 8'(busy), 8'h00);

      for (int e = 5; e <= 24; e++) begin
         applyStimulus();
         if (e >= 9) begin
            case (an)
               4'b1110: obsSeg[0] = seg;
               4'b1101: obsSeg[1] = seg;
               4'b1011: obsSeg[2] = seg;
               4'b0111: obsSeg[3] = seg;
               default: ;
            endcase
         end
      end
      checkOutput("hello0", obsSeg[0], 8'h89);
      checkOutput("hello1", obsSeg[1], 8'h86);
      checkOutput("hello2", obsSeg[2], 8'hC7);
      checkOutput("hello3", obsSeg[3], 8'hC7);

      // Long pause: nothing should scroll while refresh keeps cycling.
      pause = 1'b1;
      for (int i = 0; i < 100; i++) applyStimulus();
      pause = 1'b0;

      // Force a scroll tick to land during a mode-change fill so the pending flag is exercised.
      guard = 0;
      while (!(mFillLeft == 0 && mScrCnt == SCROLL_DIV - 3) && guard < 200) begin
         applyStimulus();
         guard++;
      end
      checkOutput("pendingSetupFound", 8'(guard < 200), 8'h01);
      mode_in = ~mode_in;
      applyStimulus();
      for (int i = 0; i < 2; i++) applyStimulus();
      checkOutput("pendingFlagModel", 8'(mPending), 8'h01);

      // Reset in the middle of a fill discards it and blanks the display.
      guard = 0;
      while (mFillLeft != 2 && guard < 200) begin
         applyStimulus();
         guard++;
      end
      rst = 1'b1;
      applyStimulus();
      checkOutput("midFillRstSeg", seg, 8'hFF);
      checkOutput("midFillRstAn", 8'(an), 8'h0F);
      checkOutput("midFillRstAdr", 8'(rom_adr), 8'h00);
      rst = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 63) == 0) mode_in = ~mode_in;
         if ($urandom_range(0, 49) == 0) pause = ~pause;
`ifdef M_SCROLL_DISP_DIR_EN
         if ($urandom_range(0, 99) == 0) dir = ~dir;
`endif
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
